decrypt_2blocks_128a: RTL and testbench
=======================================

Name: decrypt_2blocks_128a

Overview:
- Ascon-128a authenticated decryption core. Processes one 128-bit associated-data block and one 128-bit ciphertext block under a 128-bit key and nonce.
- Recovers the plaintext and checks the received tag.
- Receive-side counterpart of encrypt_2blocks_128a. Any (C, T) pair it produces from (SK, N, A, P) must decrypt here to P with tag_ok=1.
- Iterative datapath: one permutation round per clock, sequenced by an FSM.

Parameters:
- IV, 64'h80800c0800000000, Ascon-128a initialisation word (k=128, r=128, a=12, b=8).
- PA_ROUNDS, 12, rounds for initialisation and finalisation.
- PB_ROUNDS, 8, rounds for intermediate permutations.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; samples SK, N, A, C, T_in when the FSM is in IDLE.
- SK  input  128  secret key.
- N  input  128  nonce.
- A  input  128  associated-data block (always a full block).
- C  input  128  ciphertext block (always a full block).
- T_in  input  128  received tag.
- P  output  128  recovered plaintext; zero unless the tag verified.
- tag_ok  output  1  high when the computed tag equals T_in; valid while done=1 and held after.
- busy  output  1  high from the sampling edge until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- State and bit order:
  - 320-bit state x0..x4, x0 = bits [319:256].
  - All 128-bit values are big-endian: bits [127:64] map to the lower-numbered word.
- Round function:
  - Constant for round i of 12 is 8'hf0 - i*8'h0f, XORed into x2[7:0].
  - PB permutations use rounds i=4..11 (0xb4..0x4b).
  - Then the standard 5-bit S-box and linear layer, with rotations (19,28), (61,39), (1,6), (10,17), (7,41).
- Reset:
  - FSM goes to IDLE.
  - P=0, tag_ok=0, busy=0, done=0, state register=0, round counter=0, captured T_in=0.
- FSM. Edge k is the edge where start=1 is sampled in IDLE.
  - IDLE: on start, load state = IV||SK||N, capture C and T_in, busy=1 → INIT.
  - INIT: 12 rounds, edges k+1..k+12.
  - ABS_AD (k+13): x3x4 ^= SK, then x0x1 ^= A.
  - AD1: 8 rounds, k+14..k+21.
  - ABS_ADPAD (k+22): x0 ^= 64'h8000000000000000 (padding block for full-block AD).
  - AD2: 8 rounds, k+23..k+30.
  - ABS_C (k+31):
    - x4 ^= 1 (domain separation).
    - Internal Preg = x0x1 ^ C.
    - x0x1 = C.
  - PC: 8 rounds, k+32..k+39.
  - FIN_XOR (k+40): x0 ^= 64'h8000000000000000 (empty final ciphertext pad), then x2x3 ^= SK.
  - FIN: 12 rounds, k+41..k+52.
  - DONE (k+53):
    - Computed tag = x3x4 ^ SK.
    - tag_ok = (computed tag == captured T_in).
    - P = tag_ok ? Preg : 0.
    - done=1, busy=0 → IDLE.
  - Latency: done is high in the cycle after edge k+53, i.e. 53 clocks after the start sample. Back-to-back start is accepted in the cycle done is high.
- Round counter: 4-bit, cleared on each permutation entry. Exit occurs when count reaches rounds-1.
- Boundary conditions:
  - start while busy is ignored; inputs are not resampled.
  - SK, A, N may change after the start edge. SK is captured at start and used for the key XORs, so later changes on SK, A, N have no effect.
  - reset asserted mid-operation aborts on the next edge: IDLE, outputs zeroed, no done pulse.
  - start and reset in the same cycle: reset wins.
  - P and tag_ok hold their values until the next DONE or reset. They are not cleared by a new start.
  - Failed tag: P stays 0. Preg is never exposed.

Test Plan:
- Round trip:
  - Run encrypt_2blocks_128a with SK=N=A=P=128'h000102030405060708090a0b0c0d0e0f to get (C, T).
  - Feed (C, T) here → P=128'h000102...0e0f, tag_ok=1, one done pulse exactly 53 clocks after start.
- Tag corruption: same vector with T_in[0] flipped → tag_ok=0, P=0, same latency.
- Data and key corruption:
  - Flip C[127] → tag_ok=0, P=0.
  - Flip A[0] → tag_ok=0, P=0.
  - Wrong SK (all ones) → tag_ok=0.
- start held high or re-pulsed at k+20 with different inputs → single done at k+53, results match the original inputs.
- reset pulsed at k+30 → no done, busy=0, P=0, tag_ok=0. A new start after release yields correct round-trip results.
- Back-to-back: two vectors, second start in the done cycle → second done 53 clocks later. First results hold until then.

Source files
------------

// File: rtl/decrypt_2blocks_128a_if.sv
// ----------------------------------------------------------------------------
// decrypt_2blocks_128a_if : request/response bundle of the Ascon-128a decryptor.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface decrypt_2blocks_128a_if;
    logic         start;
    logic [127:0] SK;
    logic [127:0] N;
    logic [127:0] A;
    logic [127:0] C;
    logic [127:0] T_in;
    logic [127:0] P;
    logic         tag_ok;
    logic         busy;
    logic         done;

    modport master (
        output start, SK, N, A, C, T_in,
        input  P, tag_ok, busy, done
    );

    modport slave (
        input  start, SK, N, A, C, T_in,
        output P, tag_ok, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/decrypt_2blocks_128a.sv
// ----------------------------------------------------------------------------
// decrypt_2blocks_128a : iterative Ascon-128a decryption of one AD block and
//                        one ciphertext block, one permutation round per clock.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decrypt_2blocks_128a #(
    parameter logic [63:0] IV        = 64'h80800c0800000000,
    parameter int          PA_ROUNDS = 12,
    parameter int          PB_ROUNDS = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    decrypt_2blocks_128a_if.slave   bus
);

    localparam logic [3:0]  c_PA_LAST  = 4'(PA_ROUNDS - 1);
    localparam logic [3:0]  c_PB_LAST  = 4'(PB_ROUNDS - 1);
    localparam logic [3:0]  c_PB_FIRST = 4'(PA_ROUNDS - PB_ROUNDS);
    localparam logic [63:0] c_PAD      = 64'h8000000000000000;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_ABS_AD    = 4'd2,
        S_AD1       = 4'd3,
        S_ABS_ADPAD = 4'd4,
        S_AD2       = 4'd5,
        S_ABS_C     = 4'd6,
        S_PC        = 4'd7,
        S_FIN_XOR   = 4'd8,
        S_FIN       = 4'd9,
        S_DONE      = 4'd10
    } state_t;

    function automatic logic [63:0] f_ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] f_round(input logic [319:0] s, input logic [7:0] rc);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, rc};
        x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
        x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
        x0 = x0 ^ f_ror(x0, 19) ^ f_ror(x0, 28);
        x1 = x1 ^ f_ror(x1, 61) ^ f_ror(x1, 39);
        x2 = x2 ^ f_ror(x2, 1)  ^ f_ror(x2, 6);
        x3 = x3 ^ f_ror(x3, 10) ^ f_ror(x3, 17);
        x4 = x4 ^ f_ror(x4, 7)  ^ f_ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    state_t         r_state, w_state_nxt;
    logic [319:0]   r_x, w_x_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;
    logic [127:0]   r_key, w_key_nxt;
    logic [127:0]   r_a, w_a_nxt;
    logic [127:0]   r_c, w_c_nxt;
    logic [127:0]   r_t, w_t_nxt;
    logic [127:0]   r_preg, w_preg_nxt;
    logic [127:0]   r_p, w_p_nxt;
    logic           r_tag_ok, w_tag_ok_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;

    logic [3:0]     w_ridx;
    logic [7:0]     w_rc;
    logic [319:0]   w_round;
    logic [127:0]   w_tag;

    // PB permutations run the last PB_ROUNDS constants of the PA schedule
    assign w_ridx  = (r_state == S_INIT || r_state == S_FIN) ? r_cnt : r_cnt + c_PB_FIRST;
    assign w_rc    = 8'hf0 - ({4'd0, w_ridx} * 8'h0f);
    assign w_round = f_round(r_x, w_rc);
    assign w_tag   = r_x[127:0] ^ r_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_cnt    <= '0;
            r_key    <= '0;
            r_a      <= '0;
            r_c      <= '0;
            r_t      <= '0;
            r_preg   <= '0;
            r_p      <= '0;
            r_tag_ok <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_cnt    <= w_cnt_nxt;
            r_key    <= w_key_nxt;
            r_a      <= w_a_nxt;
            r_c      <= w_c_nxt;
            r_t      <= w_t_nxt;
            r_preg   <= w_preg_nxt;
            r_p      <= w_p_nxt;
            r_tag_ok <= w_tag_ok_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_cnt_nxt    = r_cnt;
        w_key_nxt    = r_key;
        w_a_nxt      = r_a;
        w_c_nxt      = r_c;
        w_t_nxt      = r_t;
        w_preg_nxt   = r_preg;
        w_p_nxt      = r_p;
        w_tag_ok_nxt = r_tag_ok;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_x_nxt     = {IV, bus.SK, bus.N};
                    w_key_nxt   = bus.SK;
                    w_a_nxt     = bus.A;
                    w_c_nxt     = bus.C;
                    w_t_nxt     = bus.T_in;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT, S_FIN: begin
                w_x_nxt = w_round;
                if (r_cnt == c_PA_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_state == S_INIT) ? S_ABS_AD : S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_AD1, S_AD2, S_PC: begin
                w_x_nxt = w_round;
                if (r_cnt == c_PB_LAST) begin
                    w_cnt_nxt = '0;
                    case (r_state)
                        S_AD1:   w_state_nxt = S_ABS_ADPAD;
                        S_AD2:   w_state_nxt = S_ABS_C;
                        default: w_state_nxt = S_FIN_XOR;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_ABS_AD: begin
                w_x_nxt[127:0]   = r_x[127:0] ^ r_key;
                w_x_nxt[319:192] = r_x[319:192] ^ r_a;
                w_state_nxt      = S_AD1;
            end
            S_ABS_ADPAD: begin
                w_x_nxt[319:256] = r_x[319:256] ^ c_PAD;
                w_state_nxt      = S_AD2;
            end
            S_ABS_C: begin
                // Decryption overwrites the rate with the ciphertext itself
                w_preg_nxt       = r_x[319:192] ^ r_c;
                w_x_nxt[319:192] = r_c;
                w_x_nxt[0]       = ~r_x[0];
                w_state_nxt      = S_PC;
            end
            S_FIN_XOR: begin
                w_x_nxt[319:256] = r_x[319:256] ^ c_PAD;
                w_x_nxt[191:64]  = r_x[191:64] ^ r_key;
                w_state_nxt      = S_FIN;
            end
            S_DONE: begin
                w_tag_ok_nxt = (w_tag == r_t);
                w_p_nxt      = (w_tag == r_t) ? r_preg : '0;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.P      = r_p;
    assign bus.tag_ok = r_tag_ok;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_decrypt_2blocks_128a.sv
// ----------------------------------------------------------------------------
// tb_decrypt_2blocks_128a : directed round-trip bench; (C,T) come from an
//                           encrypt-side Ascon-128a reference in the bench.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decrypt_2blocks_128a;

    localparam logic [127:0] c_V0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_N2   = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] c_A2   = 128'h11223344556677889900aabbccddeeff;
    localparam logic [127:0] c_P2   = 128'hdeadbeefcafebabe0badf00d12345678;
    localparam logic [63:0]  c_IV   = 64'h80800c0800000000;
    localparam logic [63:0]  c_PAD  = 64'h8000000000000000;
    localparam int           c_LAT  = 53;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    decrypt_2blocks_128a_if ifc ();

    decrypt_2blocks_128a dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference permutation on a word array; rounds first..first+nr-1
    function automatic logic [319:0] perm(input logic [319:0] s_in, input int first, input int nr);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int          ra [5];
        int          rb [5];
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        for (int w = 0; w < 5; w++) x[w] = s_in[319 - 64*w -: 64];
        for (int r = first; r < first + nr; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(240 - 15 * r);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int w = 0; w < 5; w++) t[w] = ~x[w] & x[(w + 1) % 5];
            for (int w = 0; w < 5; w++) x[w] ^= t[(w + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            for (int w = 0; w < 5; w++)
                x[w] = x[w] ^ ((x[w] >> ra[w]) | (x[w] << (64 - ra[w])))
                            ^ ((x[w] >> rb[w]) | (x[w] << (64 - rb[w])));
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic enc(input logic [127:0] k, n, a, p, output logic [127:0] c, t);
        logic [319:0] s;
        s = perm({c_IV, k, n}, 0, 12);
        s[127:0]   ^= k;
        s[319:192] ^= a;
        s = perm(s, 4, 8);
        s[319:256] ^= c_PAD;
        s = perm(s, 4, 8);
        s[0]       ^= 1'b1;
        s[319:192] ^= p;
        c = s[319:192];
        s = perm(s, 4, 8);
        s[319:256] ^= c_PAD;
        s[191:64]  ^= k;
        s = perm(s, 0, 12);
        t = s[127:0] ^ k;
    endtask

    // Called #1 after an edge; the next edge samples start
    task automatic kick(input logic [127:0] k, n, a, c, t);
        ifc.start = 1'b1;
        ifc.SK = k; ifc.N = n; ifc.A = a; ifc.C = c; ifc.T_in = t;
        @(posedge clk); #1;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int disturb, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ifc.done) break;
            if (disturb != 0 && lat == disturb) begin
                ifc.start = 1'b1;
                ifc.SK = ~ifc.SK; ifc.N = ~ifc.N; ifc.A = ~ifc.A;
                ifc.C = ~ifc.C; ifc.T_in = ~ifc.T_in;
            end else begin
                ifc.start = 1'b0;
            end
        end
        ifc.start = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ifc.done) nd++;
        end
    endtask

    initial begin
        logic [127:0] c0, t0, c1, t1;
        int           lat;
        int           nd;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        ifc.start = 1'b0;
        ifc.SK = '0; ifc.N = '0; ifc.A = '0; ifc.C = '0; ifc.T_in = '0;
        enc(c_V0, c_V0, c_V0, c_V0, c0, t0);
        enc(c_V0, c_N2, c_A2, c_P2, c1, t1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_P", ifc.P, '0);
        chk("rst_tag_ok", 128'(ifc.tag_ok), '0);
        chk("rst_busy", 128'(ifc.busy), '0);
        chk("rst_done", 128'(ifc.done), '0);
        reset = 1'b0;
        @(posedge clk); #1;

        kick(c_V0, c_V0, c_V0, c0, t0);
        chk("rt_busy", 128'(ifc.busy), 128'd1);
        wait_done(0, lat);
        chk("rt_latency", 128'(lat), 128'(c_LAT));
        chk("rt_P", ifc.P, c_V0);
        chk("rt_tag_ok", 128'(ifc.tag_ok), 128'd1);
        chk("rt_busy_done", 128'(ifc.busy), '0);
        @(posedge clk); #1;
        chk("rt_done_pulse", 128'(ifc.done), '0);
        chk("rt_P_hold", ifc.P, c_V0);

        kick(c_V0, c_V0, c_V0, c0, t0 ^ 128'd1);
        wait_done(0, lat);
        chk("badtag_latency", 128'(lat), 128'(c_LAT));
        chk("badtag_tag_ok", 128'(ifc.tag_ok), '0);
        chk("badtag_P", ifc.P, '0);

        kick(c_V0, c_V0, c_V0, c0 ^ {1'b1, 127'd0}, t0);
        wait_done(0, lat);
        chk("badc_tag_ok", 128'(ifc.tag_ok), '0);
        chk("badc_P", ifc.P, '0);

        kick(c_V0, c_V0, c_V0 ^ 128'd1, c0, t0);
        wait_done(0, lat);
        chk("bada_tag_ok", 128'(ifc.tag_ok), '0);
        chk("bada_P", ifc.P, '0);

        kick('1, c_V0, c_V0, c0, t0);
        wait_done(0, lat);
        chk("badk_tag_ok", 128'(ifc.tag_ok), '0);
        chk("badk_P", ifc.P, '0);

        kick(c_V0, c_V0, c_V0, c0, t0);
        wait_done(20, lat);
        chk("restart_latency", 128'(lat), 128'(c_LAT));
        chk("restart_P", ifc.P, c_V0);
        chk("restart_tag_ok", 128'(ifc.tag_ok), 128'd1);
        count_dones(60, nd);
        chk("restart_extra_done", 128'(nd), '0);

        kick(c_V0, c_V0, c_V0, c0, t0);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ifc.start = 1'b0;
        chk("abort_busy", 128'(ifc.busy), '0);
        chk("abort_P", ifc.P, '0);
        chk("abort_tag_ok", 128'(ifc.tag_ok), '0);
        count_dones(60, nd);
        chk("abort_no_done", 128'(nd), '0);
        kick(c_V0, c_V0, c_V0, c0, t0);
        wait_done(0, lat);
        chk("after_abort_latency", 128'(lat), 128'(c_LAT));
        chk("after_abort_P", ifc.P, c_V0);
        chk("after_abort_tag_ok", 128'(ifc.tag_ok), 128'd1);

        kick(c_V0, c_N2, c_A2, c1, t1);
        chk("b2b_P_hold", ifc.P, c_V0);
        chk("b2b_tag_hold", 128'(ifc.tag_ok), 128'd1);
        chk("b2b_busy", 128'(ifc.busy), 128'd1);
        wait_done(0, lat);
        chk("b2b_latency", 128'(lat), 128'(c_LAT));
        chk("b2b_P", ifc.P, c_P2);
        chk("b2b_tag_ok", 128'(ifc.tag_ok), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
